// File: rtl/stopwatch_display.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_display
//
// Purpose:
//   Display back-end for the stopwatch core. A minutes/seconds/status snapshot
//   is taken once per display frame. It is converted to BCD by a sequential
//   double-dabble engine, then shown on a 4-digit multiplexed 7-segment display
//   as MM:SS. The colon (dp on digit 2) and the blanking depend on the status.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   minutes    in   [7:0] binary minutes (values above 99 clamp to 99)
//   seconds    in   [5:0] binary seconds (60..63 pass through unclamped)
//   status     in   [1:0] 00 IDLE, 01 RUNNING, 10 PAUSED, 11 reserved (dashes)
//   seg        out  [6:0] segments {g,f,e,d,c,b,a}
//   dp         out  decimal point / colon, lit only on digit 2
//   an         out  [3:0] digit enables, an[3]=minute tens .. an[0]=second units
//   conv_busy  out  high while a BCD conversion is in flight
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank the minute-tens digit when it is 0.
//
// Converter FSM:
//   state    | meaning
//   ST_IDLE  | waiting for the next frame snapshot
//   ST_SHIFT | 8 add-3/shift steps on both lanes
//   ST_LOAD  | copy BCD result and status into the display registers
// -----------------------------------------------------------------------------
module stopwatch_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       conv_busy
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    POL7       = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]    POL4       = {4{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_t;

    conv_state_t r_state;
    conv_state_t w_state_nxt;

    logic [RW-1:0] r_ref_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [1:0]    r_digit;
    logic          r_started;
    logic [15:0]   r_min_sr;
    logic [15:0]   r_sec_sr;
    logic [2:0]    r_shift_cnt;
    logic [1:0]    r_snap_status;
    logic [7:0]    r_disp_min;
    logic [7:0]    r_disp_sec;
    logic [1:0]    r_disp_status;

    logic          w_ref_wrap;
    logic          w_snap;
    logic [7:0]    w_min_clamped;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_ah;
    logic          w_dp_ah;
    logic [3:0]    w_an_ah;

    // One double-dabble step on a {bcd[7:0], bin[7:0]} lane.
    function automatic logic [15:0] dabble_step(input logic [15:0] v_in);
        logic [15:0] v;
        v = v_in;
        if (v[11:8] >= 4'd5) v[11:8] = v[11:8] + 4'd3;
        if (v[15:12] >= 4'd5) v[15:12] = v[15:12] + 4'd3;
        return {v[14:0], 1'b0};
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign w_ref_wrap    = (r_ref_cnt == REF_LAST);
    // A frame starts when the digit index rolls over from 0 to 3.
    assign w_snap        = w_ref_wrap && (r_digit == 2'd0) && (r_state == ST_IDLE);
    assign w_min_clamped = (minutes > 8'd99) ? 8'd99 : minutes;

    // Refresh and blink timing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt   <= '0;
            r_digit     <= 2'd0;
            r_started   <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            if (w_ref_wrap) begin
                r_ref_cnt <= '0;
                r_digit   <= r_digit - 2'd1;
                r_started <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + RW'(1);
            end
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Converter FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_snap) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_shift_cnt == 3'd7) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Converter datapath; display registers are only written in ST_LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_sr      <= '0;
            r_sec_sr      <= '0;
            r_shift_cnt   <= '0;
            r_snap_status <= 2'd0;
            r_disp_min    <= '0;
            r_disp_sec    <= '0;
            r_disp_status <= 2'd0;
            conv_busy     <= 1'b0;
        end else begin
            // Held through the LOAD edge, so it drops together with the new digits.
            conv_busy <= w_snap || (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_snap) begin
                        r_min_sr      <= {8'd0, w_min_clamped};
                        r_sec_sr      <= {8'd0, 2'b00, seconds};
                        r_snap_status <= status;
                        r_shift_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_min_sr    <= dabble_step(r_min_sr);
                    r_sec_sr    <= dabble_step(r_sec_sr);
                    r_shift_cnt <= r_shift_cnt + 3'd1;
                end
                ST_LOAD: begin
                    r_disp_min    <= r_min_sr[15:8];
                    r_disp_sec    <= r_sec_sr[15:8];
                    r_disp_status <= r_snap_status;
                end
                default: ;
            endcase
        end
    end

    // Output pattern for the current digit, in active-high form.
    always_comb begin
        w_nib    = 4'd0;
        w_seg_ah = 7'b0000000;
        w_dp_ah  = 1'b0;
        w_an_ah  = 4'b0000;
        case (r_digit)
            2'd3:    w_nib = r_disp_min[7:4];
            2'd2:    w_nib = r_disp_min[3:0];
            2'd1:    w_nib = r_disp_sec[7:4];
            default: w_nib = r_disp_sec[3:0];
        endcase
        // Stay dark until the first refresh period has elapsed after reset.
        if (r_started && !(r_disp_status == 2'b10 && !r_blink_on)) begin
            w_an_ah = 4'b0001 << r_digit;
            if (r_disp_status == 2'b11) begin
                w_seg_ah = 7'b1000000;
            end else begin
                w_seg_ah = seg_decode(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
                if (r_digit == 2'd3 && w_nib == 4'd0) w_seg_ah = 7'b0000000;
`endif
                if (r_disp_status == 2'b01)
                    w_dp_ah = (r_digit == 2'd2) && r_blink_on;
                else if (r_disp_status == 2'b10)
                    w_dp_ah = (r_digit == 2'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= POL7;
            dp  <= SEG_ACTIVE_LOW;
            an  <= POL4;
        end else begin
            seg <= w_seg_ah ^ POL7;
            dp  <= w_dp_ah ^ SEG_ACTIVE_LOW;
            an  <= w_an_ah ^ POL4;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
`timescale 1ns/1ps
module tb_stopwatch_display;

    localparam int REFRESH_DIV    = 4;
    localparam int BLINK_DIV      = 16;
    localparam bit SEG_ACTIVE_LOW = 1'b1;

    // Active-high reference patterns {g,f,e,d,c,b,a} for 0..9.
    localparam logic [6:0] SEG_TAB [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] minutes = 8'd0;
    logic [5:0] seconds = 6'd0;
    logic [1:0] status = 2'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       conv_busy;

    stopwatch_display #(
        .REFRESH_DIV   (REFRESH_DIV),
        .BLINK_DIV     (BLINK_DIV),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .minutes  (minutes),
        .seconds  (seconds),
        .status   (status),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .conv_busy(conv_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  an;
        logic        busy;
        logic [31:0] kk;
    } exp_t;

    typedef struct packed {
        logic [7:0] min;
        logic [5:0] sec;
        logic [1:0] st;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         k = 0;
    bit         chk_en = 1'b0;
    logic [1:0] m_st = 2'd0;
    logic [3:0] m_d [4];
    exp_t       sb_q [$];
    exp_t       sb_e;
    vec_t       vecs [9];

    // Expected outputs after the kk-th rising edge since reset release.
    function automatic exp_t model(input int kk);
        exp_t       e;
        int         j;
        int         dig;
        bit         ph;
        logic [6:0] pat;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.an   = 4'hF;
        e.kk   = kk;
        e.busy = (kk >= 4) && (((kk - 4) % 16) < 10);
        if (kk < 5) return e;
        j   = kk - 1;
        dig = (4 - ((j / 4) % 4)) % 4;
        ph  = ((j / 16) % 2) == 0;
        if (m_st == 2'b10 && !ph) return e;
        e.an = 4'hF ^ (4'b0001 << dig);
        if (m_st == 2'b11) begin
            e.seg = 7'b0111111;
        end else begin
            pat = SEG_TAB[m_d[dig]];
`ifdef LEADING_ZERO_BLANK_EN
            if (dig == 3 && m_d[3] == 4'd0) pat = 7'h00;
`endif
            e.seg = ~pat;
            if (m_st == 2'b01 && dig == 2 && ph) e.dp = 1'b0;
            if (m_st == 2'b10 && dig == 2) e.dp = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) k = 0;
        else     k = k + 1;
        if (chk_en) sb_q.push_back(model(k));
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            n_chk++;
            if ({seg, dp, an, conv_busy} !== {sb_e.seg, sb_e.dp, sb_e.an, sb_e.busy}) begin
                n_fail++;
                $display("FAIL sb k=%0d: got seg=%b dp=%b an=%b busy=%b, expected seg=%b dp=%b an=%b busy=%b",
                         sb_e.kk, seg, dp, an, conv_busy, sb_e.seg, sb_e.dp, sb_e.an, sb_e.busy);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_level(input logic lvl, input int bound, input string what);
        int n;
        n = 0;
        while (conv_busy !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (conv_busy !== lvl) begin
            n_fail++;
            $display("FAIL %s: conv_busy=%b after %0d cycles, expected %b", what, conv_busy, bound, lvl);
        end
    endtask

    task automatic set_model(input vec_t v);
        m_st   = v.st;
        m_d[3] = v.d3;
        m_d[2] = v.d2;
        m_d[1] = v.d1;
        m_d[0] = v.d0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        minutes = v.min;
        seconds = v.sec;
        status  = v.st;
        wait_level(1'b0, 20, "pre_idle");
        wait_level(1'b1, 40, "conv_start");
        wait_level(1'b0, 20, "conv_done");
        set_model(v);
        chk_en = 1'b1;
        repeat (32) @(negedge clk);
        chk_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{8'd42,  6'd37, 2'b00, 4'd4, 4'd2, 4'd3, 4'd7};
        vecs[1] = '{8'd150, 6'd59, 2'b00, 4'd9, 4'd9, 4'd5, 4'd9};
        vecs[2] = '{8'd0,   6'd0,  2'b00, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[3] = '{8'd99,  6'd63, 2'b00, 4'd9, 4'd9, 4'd6, 4'd3};
        vecs[4] = '{8'd5,   6'd7,  2'b01, 4'd0, 4'd5, 4'd0, 4'd7};
        vecs[5] = '{8'd12,  6'd34, 2'b10, 4'd1, 4'd2, 4'd3, 4'd4};
        vecs[6] = '{8'd88,  6'd10, 2'b11, 4'd8, 4'd8, 4'd1, 4'd0};
        vecs[7] = '{8'd100, 6'd60, 2'b01, 4'd9, 4'd9, 4'd6, 4'd0};
        vecs[8] = '{8'd255, 6'd9,  2'b10, 4'd9, 4'd9, 4'd0, 4'd9};

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_seg",  32'(seg), 32'h7F);
        check("rst_dp",   32'(dp), 32'h1);
        check("rst_an",   32'(an), 32'hF);
        check("rst_busy", 32'(conv_busy), 32'h0);

        // Digit walk, busy timing and all-zero display straight after release
        m_st = 2'b00;
        for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset during the 4th shift cycle
        @(negedge clk);
        minutes = 8'd42;
        seconds = 6'd37;
        status  = 2'b00;
        wait_level(1'b0, 20, "mid_pre_idle");
        wait_level(1'b1, 40, "mid_conv_start");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(conv_busy), 32'h0);
        check("mid_rst_an",   32'(an), 32'hF);
        check("mid_rst_seg",  32'(seg), 32'h7F);
        check("mid_rst_dp",   32'(dp), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_an", 32'(an), 32'h7);
`ifdef LEADING_ZERO_BLANK_EN
        check("post_rst_seg0", 32'(seg), 32'h7F);
`else
        check("post_rst_seg0", 32'(seg), 32'h40);
`endif
        wait_level(1'b0, 20, "post_rst_conv_done");
        v = '{8'd42, 6'd37, 2'b00, 4'd4, 4'd2, 4'd3, 4'd7};
        set_model(v);
        chk_en = 1'b1;
        repeat (32) @(negedge clk);
        chk_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d comparisons so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
